// File: rtl/adder_tree_pkg.sv
// ============================================================================
//  Module      : adder_tree_pkg
//  Description : Shared sizing helpers for the pipelined adder tree.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_tree_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_N     = 4;

  // Number of register stages needed to reduce n operands to one.
  function automatic int tree_levels(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Width of the loss-free final sum.
  function automatic int full_width(input int width, input int n);
    return width + tree_levels(n);
  endfunction

  // Bit offset of tree boundary b inside the flat inter-stage bus.
  // Boundary b carries (2**levels >> b) values of width+b bits each.
  function automatic int bus_offset(input int width, input int levels, input int b);
    int off;
    off = 0;
    for (int i = 0; i < b; i++) begin
      off += ((1 << levels) >> i) * (width + i);
    end
    return off;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_tree_stage.sv
// ============================================================================
//  Module      : adder_tree_stage
//  Description : One level of the adder tree: PAIRS registered pairwise sums
//                with a valid bit and local load/advance handshake logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_stage #(
  parameter int IN_W  = 8,
  parameter int PAIRS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           up_valid,
  output logic                           up_ready,
  input  logic [2*PAIRS-1:0][IN_W-1:0]   operands,
  output logic                           down_valid,
  input  logic                           down_ready,
  output logic [PAIRS-1:0][IN_W:0]       sums
);

  logic                     valid_q;
  logic                     advance;
  logic                     load;
  logic [PAIRS-1:0][IN_W:0] sums_d;

  // An occupied stage can be refilled in the same cycle it hands its data on,
  // and an empty stage is simply overwritten, which collapses bubbles.
  assign advance    = valid_q && down_ready;
  assign up_ready   = !valid_q || advance;
  assign load       = up_valid && up_ready;
  assign down_valid = valid_q;

  // Pairwise sums, one bit wider than the inputs so nothing is lost.
  always_comb begin
    sums_d = '0;
    for (int p = 0; p < PAIRS; p++) begin
      sums_d[p] = {1'b0, operands[2*p]} + {1'b0, operands[2*p+1]};
    end
  end

  // Occupancy flag: set on load, cleared when the content moves on unreplaced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (advance) begin
      valid_q <= 1'b0;
    end
  end

  // Partial-sum register, written only on a load so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sums <= '0;
    end else if (load) begin
      sums <= sums_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder_tree.sv
// ============================================================================
//  Module      : pipelined_adder_tree
//  Description : Sums N unsigned WIDTH-bit operands through a registered binary
//                tree (one stage per level) with valid/ready on both sides.
//                Optional macro ADDER_TREE_SAT_EN: saturate a narrowed result
//                instead of wrapping it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder_tree
  import adder_tree_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int N         = DEFAULT_N,
  parameter int OUT_WIDTH = full_width(WIDTH, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in [N-1:0],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] sum,
  output logic                 overflow
);

  localparam int LEVELS = tree_levels(N);
  localparam int P      = 1 << LEVELS;
  localparam int FULL_W = full_width(WIDTH, N);
  localparam int BUS_W  = bus_offset(WIDTH, LEVELS, LEVELS + 1);

  // Flat bus holding every tree boundary back to back: padded operands first,
  // then each stage's registered partial sums, ending with the final sum.
  logic [BUS_W-1:0]  tree_bus;
  logic [LEVELS:0]   vld;
  logic [LEVELS:0]   rdy;
  logic [FULL_W-1:0] full_sum;

  assign vld[0]      = in_valid;
  assign in_ready    = rdy[0];
  assign out_valid   = vld[LEVELS];
  assign rdy[LEVELS] = out_ready;

  // Zero-pad the operand set up to a power of two.
  for (genvar j = 0; j < P; j++) begin : g_pad
    if (j < N) begin : g_opnd
      assign tree_bus[j*WIDTH +: WIDTH] = in[j];
    end else begin : g_zero
      assign tree_bus[j*WIDTH +: WIDTH] = '0;
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int IN_W    = WIDTH + k;
    localparam int PAIRS   = P >> (k + 1);
    localparam int IN_OFF  = bus_offset(WIDTH, LEVELS, k);
    localparam int OUT_OFF = bus_offset(WIDTH, LEVELS, k + 1);

    adder_tree_stage #(
      .IN_W  (IN_W),
      .PAIRS (PAIRS)
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (vld[k]),
      .up_ready   (rdy[k]),
      .operands   (tree_bus[IN_OFF +: 2*PAIRS*IN_W]),
      .down_valid (vld[k+1]),
      .down_ready (rdy[k+1]),
      .sums       (tree_bus[OUT_OFF +: PAIRS*(IN_W+1)])
    );
  end

  assign full_sum = tree_bus[BUS_W-1 -: FULL_W];

  // Fit the full-precision result into OUT_WIDTH bits.
  if (OUT_WIDTH >= FULL_W) begin : g_full_out
    assign sum      = full_sum;
    assign overflow = 1'b0;
  end else begin : g_narrow_out
    assign overflow = |full_sum[FULL_W-1:OUT_WIDTH];
`ifdef ADDER_TREE_SAT_EN
    assign sum = overflow ? {OUT_WIDTH{1'b1}} : full_sum[OUT_WIDTH-1:0];
`else
    assign sum = full_sum[OUT_WIDTH-1:0];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder_tree.sv
// ============================================================================
//  Module      : tb_pipelined_adder_tree
//  Description : Self-checking bench for pipelined_adder_tree: latency, width
//                narrowing, non-power-of-two N, backpressure, bubbles, reset.
//                Honours ADDER_TREE_SAT_EN for the narrowed-output check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_adder_tree;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT: WIDTH=8, N=4, full-width output
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a [3:0];
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] sum;
  logic       overflow;

  // Narrowed DUT: WIDTH=8, N=4, OUT_WIDTH=8
  logic       in_valid_b = 1'b0;
  logic       in_ready_b;
  logic [7:0] in_b [3:0];
  logic       out_valid_b;
  logic [7:0] sum_b;
  logic       overflow_b;

  // Non-power-of-two DUT: WIDTH=16, N=5
  logic        in_valid_c = 1'b0;
  logic        in_ready_c;
  logic [15:0] in_c [4:0];
  logic        out_valid_c;
  logic [18:0] sum_c;
  logic        overflow_c;

  pipelined_adder_tree #(.WIDTH(8), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .overflow(overflow)
  );

  pipelined_adder_tree #(.WIDTH(8), .N(4), .OUT_WIDTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in(in_b),
    .out_valid(out_valid_b), .out_ready(1'b1), .sum(sum_b), .overflow(overflow_b)
  );

  pipelined_adder_tree #(.WIDTH(16), .N(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c), .in(in_c),
    .out_valid(out_valid_c), .out_ready(1'b1), .sum(sum_c), .overflow(overflow_c)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected sums pushed on accepted inputs, popped on outputs.
  logic [9:0] sb_q [$];
  logic       stall_prev = 1'b0;
  logic [9:0] sum_prev   = '0;

  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (stall_prev) chk("stall_sum_stable", sum, sum_prev);
      if (in_valid && in_ready) begin
        e = 10'(in_a[0]) + 10'(in_a[1]) + 10'(in_a[2]) + 10'(in_a[3]);
        sb_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_sum", sum, e);
          chk("sb_overflow", overflow, 0);
        end
      end
      stall_prev = out_valid && !out_ready;
      sum_prev   = sum;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // out_ready policy: 0 = high, 1 = low, 2 = random; stall_cnt forces low first.
  int ready_mode = 0;
  int stall_cnt  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_cnt > 0) begin
      out_ready = 1'b0;
      stall_cnt--;
    end else if (ready_mode == 2) begin
      out_ready = ($urandom_range(0, 1) != 0);
    end else begin
      out_ready = (ready_mode == 0);
    end
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    bit ok;
    int guard;
    in_a[0] = 8'(a); in_a[1] = 8'(b); in_a[2] = 8'(c); in_a[3] = 8'(d);
    in_valid = 1'b1;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 100) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      guard++;
    end
    if (!ok) chk("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < 4; i++) begin in_a[i] = '0; in_b[i] = 8'd255; end
    in_c[0] = 16'd1000; in_c[1] = 16'd1100; in_c[2] = 16'd1200;
    in_c[3] = 16'd1300; in_c[4] = 16'd1400;

    // Reset state
    #22 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);

    // Narrowed output: 4 x 255 = 1020 -> wraps to 252 or saturates to 255
    in_valid_b = 1'b1;
    @(negedge clk);
    chk("b_in_ready", in_ready_b, 1);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    @(negedge clk);
    chk("b_latency_early", out_valid_b, 0);
    @(negedge clk);
    chk("b_out_valid", out_valid_b, 1);
`ifdef ADDER_TREE_SAT_EN
    chk("b_sum", sum_b, 255);
`else
    chk("b_sum", sum_b, 252);
`endif
    chk("b_overflow", overflow_b, 1);

    // N=5 padded to 8: three stages, 6000
    @(posedge clk); #1;
    in_valid_c = 1'b1;
    @(negedge clk);
    chk("c_in_ready", in_ready_c, 1);
    @(posedge clk); #1;
    in_valid_c = 1'b0;
    @(negedge clk);
    chk("c_latency_1", out_valid_c, 0);
    @(negedge clk);
    chk("c_latency_2", out_valid_c, 0);
    @(negedge clk);
    chk("c_out_valid", out_valid_c, 1);
    chk("c_sum", sum_c, 6000);
    chk("c_overflow", overflow_c, 0);

    // Basic sum with exact two-cycle latency
    @(posedge clk); #1;
    ready_mode = 0;
    send(10, 20, 30, 40);
    @(negedge clk);
    chk("t1_latency_early", out_valid, 0);
    @(negedge clk);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_sum", sum, 100);
    chk("t1_overflow", overflow, 0);
    tick();

    // Backpressure: 10 vectors, 6 stalled cycles, then random out_ready
    ready_mode = 2;
    out_ready  = 1'b0;
    stall_cnt  = 6;
    send(0, 1, 255, 0);
    send(7, 14, 254, 31);
    in_a[0] = 8'd14; in_a[1] = 8'd27; in_a[2] = 8'd253; in_a[3] = 8'd62;
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_buffered", sb_q.size(), 2);
    chk("bp_out_valid", out_valid, 1);
    tick();
    for (int i = 2; i < 10; i++) send(i*7, i*13+1, 255-i, (i*31) % 256);
    ready_mode = 0;
    g = 0;
    while (sb_q.size() != 0 && g < 100) begin tick(); g++; end
    chk("bp_drained", sb_q.size(), 0);

    // Full pipeline with out_ready=1 accepts while the oldest leaves
    ready_mode = 1;
    tick();
    send(200, 100, 50, 25);
    send(1, 2, 3, 4);
    in_a[0] = 8'd9; in_a[1] = 8'd8; in_a[2] = 8'd7; in_a[3] = 8'd6;
    in_valid  = 1'b1;
    ready_mode = 0;
    out_ready  = 1'b1;
    @(negedge clk);
    chk("simul_in_ready", in_ready, 1);
    chk("simul_out_valid", out_valid, 1);
    tick();
    in_valid = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 20) begin tick(); g++; end
    chk("simul_drained", sb_q.size(), 0);

    // Bubbles: valid 1,0,1,0 while stalled, then consecutive release
    ready_mode = 1;
    tick();
    send(11, 22, 33, 44);
    tick();
    send(5, 6, 7, 8);
    @(negedge clk);
    chk("bub_in_ready_full", in_ready, 0);
    tick();
    ready_mode = 0;
    out_ready  = 1'b1;
    @(negedge clk);
    chk("bub_first", out_valid, 1);
    tick();
    @(negedge clk);
    chk("bub_second", out_valid, 1);
    tick();
    @(negedge clk);
    chk("bub_empty", out_valid, 0);
    chk("bub_drained", sb_q.size(), 0);
    tick();

    // Reset with two vectors in flight
    send(100, 1, 1, 1);
    send(50, 50, 50, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_out_valid", out_valid, 0);
    chk("rr_sum", sum, 0);
    sb_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rr_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_no_stale", out_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_adder_tree.md
Name: pipelined_adder_tree

Overview:
- Next generation of the combinational adder tree: sums N unsigned WIDTH-bit operands through a registered binary tree, one pipeline stage per tree level.
- Operand vectors enter and sums leave on valid/ready handshakes.
- Full backpressure and bubble collapsing let it sit between streaming producers and consumers in datapath blocks.

Parameters:
- WIDTH, 8, bit width of each operand (>=1).
- N, 4, operand count (>=2; need not be a power of two).
- OUT_WIDTH, WIDTH+$clog2(N), result width (1..WIDTH+$clog2(N)).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand vector valid
- in_ready  output  1  block can accept the operand vector
- in  input  [WIDTH-1:0] x N (unpacked [N-1:0])  operands
- out_valid  output  1  sum valid
- out_ready  input  1  consumer accepts the sum
- sum  output  OUT_WIDTH  result
- overflow  output  1  full-precision sum did not fit in OUT_WIDTH; qualified by out_valid

Behaviour:
- Tree structure:
  - LEVELS = $clog2(N) register stages.
  - Operands are zero-padded to P = 2**LEVELS.
  - Stage k holds P>>(k+1) partial sums, each WIDTH+k+1 bits wide, so there is no intermediate loss.
- Each stage k has a valid bit v[k].
  - Stage k loads when its input is valid and (!v[k] or stage k advances).
  - Stage k advances when v[k] and (k is last ? out_ready : (!v[k+1] or stage k+1 advances)).
  - Empty stages are overwritten, which collapses bubbles.
- in_ready = !v[0] or stage 0 advances. It is combinational from out_ready through the valid chain; there is no ready register.
- A transfer occurs on the rising edge where in_valid && in_ready. Operands are sampled only on that edge.
- out_valid = v[LEVELS-1]. sum and overflow hold stable while out_valid && !out_ready.
- Latency: an accepted vector appears on out_valid LEVELS cycles later with no backpressure. Throughput is 1 vector/cycle with out_ready tied high.
- Ordering: strict FIFO. No result is dropped or duplicated under any stall pattern.
- Width rule:
  - The full-precision result F is WIDTH+LEVELS bits.
  - If OUT_WIDTH equals the full width, sum = F and overflow = 0.
  - Otherwise sum = F[OUT_WIDTH-1:0] (modulo wrap) and overflow = |F[full-1:OUT_WIDTH].
- Reset, asynchronous:
  - All v[k] = 0, so out_valid = 0.
  - sum = 0, overflow = 0, and all partial-sum registers = 0.
  - in_ready = 1 after reset.
  - Reset mid-operation discards all in-flight vectors. No output is produced for them after reset release.
- Simultaneous events: with the pipeline full and out_ready = 1, a new input is accepted in the same cycle the oldest result leaves.
- in_valid must not be withdrawn before acceptance (protocol rule; the bench checks the producer side only).

Optional Feature:
- Macro: ADDER_TREE_SAT_EN
- Defined: when OUT_WIDTH is less than the full width and F exceeds 2**OUT_WIDTH-1, sum saturates to 2**OUT_WIDTH-1. overflow is still asserted.
- Undefined: wrap behaviour as specified above.
- With the full-width OUT_WIDTH, both builds are identical.

Decomposition:
- Package adder_tree_pkg:
  - functions tree_levels(N) and full_width(WIDTH, N).
  - localparam defaults for WIDTH and N.
- Sub-module adder_tree_stage:
  - Parameters IN_W and PAIRS.
  - Registers PAIRS pairwise sums of IN_W+1 bits, with valid and local load/advance logic.
- The top is a generate loop over LEVELS instances plus output width/saturation logic.

Test Plan:
1. WIDTH=8, N=4, out_ready=1.
   - Stimulus: in {10,20,30,40}.
   - Response: sum=100 exactly 2 cycles after acceptance; overflow=0.
2. WIDTH=8, N=4, OUT_WIDTH=8.
   - Stimulus: {255,255,255,255}.
   - Response: sum=252, overflow=1. With ADDER_TREE_SAT_EN: sum=255, overflow=1.
3. WIDTH=16, N=5 (zero-padded to 8, 3 stages).
   - Stimulus: {1000,1100,1200,1300,1400}.
   - Response: sum=6000 after 3 cycles; OUT_WIDTH=19.
4. Backpressure.
   - Stimulus: stream 10 vectors back-to-back, hold out_ready=0 for 6 cycles, then randomise out_ready.
   - Response: at most LEVELS vectors buffered, then in_ready=0. Sums match the scoreboard in order. sum is stable while stalled.
5. Bubbles.
   - Stimulus: in_valid pattern 1,0,1,0 with out_ready=0, then release.
   - Response: the pipeline compacts; results emerge on consecutive cycles after release.
6. Reset mid-flight.
   - Stimulus: assert rst_n=0 asynchronously while 2 vectors are in flight.
   - Response: out_valid=0, sum=0 immediately. No stale output after release. in_ready=1 on the first post-reset cycle.
